// File: rtl/tb_status_responder.sv
// Bus-slave end of the testbench pass/fail/exit signalling: decodes a 32-byte register
// window, buffers stdout characters and holds termination until every character is drained.
module tb_status_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        char_valid_o,
  output logic [7:0]  char_data_o,
  input  logic        char_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count, count_d;
  logic [63:0] cyc_q, cyc_d;
  logic [31:0] cyc_hi_q, cyc_hi_d;
  logic        rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pass_pend_q, pass_pend_d, fail_pend_q, fail_pend_d, exit_pend_q, exit_pend_d;
  logic [31:0] exit_val_q, exit_val_d;
  logic        passed_q, passed_d, failed_q, failed_d, exit_valid_q, exit_valid_d;
  logic [31:0] exit_value_q, exit_value_d;

  logic        in_win, reg_ok, full, empty, print_wr, push, pop, term_wr;
  logic [2:0]  off;
  logic        unused_be;

  assign unused_be = ^data_be_i[3:1];
  assign in_win    = (data_addr_i[31:5] == BASE_ADDR[31:5]);
  assign off       = data_addr_i[4:2];
  // Offset 0x1C lies inside the window but maps to no register.
  assign reg_ok    = in_win && (data_addr_i[1:0] == 2'b00) && (off != 3'd7);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign print_wr  = data_req_i && data_we_i && reg_ok && (off == 3'd0);
  assign data_gnt_o = data_req_i && !(print_wr && full);
  assign push      = data_gnt_o && print_wr && data_be_i[0];
  assign pop       = !empty && char_ready_i;
  assign term_wr   = data_gnt_o && data_we_i && reg_ok && (off inside {3'd1, 3'd2, 3'd3});

  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d      = wr_ptr_d - rd_ptr_d;
    cyc_d        = cyc_q + 64'd1;
    cyc_hi_d     = cyc_hi_q;
    rvalid_d     = data_gnt_o;
    rdata_d      = '0;
    err_d        = 1'b0;
    pass_pend_d  = pass_pend_q;
    fail_pend_d  = fail_pend_q;
    exit_pend_d  = exit_pend_q;
    exit_val_d   = exit_val_q;
    state_d      = state_q;
    passed_d     = 1'b0;
    failed_d     = 1'b0;
    exit_valid_d = 1'b0;
    exit_value_d = '0;

    if (data_gnt_o) begin
      if (!reg_ok) begin
        err_d = 1'b1;
      end else if (!data_we_i) begin
        case (off)
          3'd4: begin
            rdata_d  = cyc_q[31:0];
            cyc_hi_d = cyc_q[63:32];
          end
          3'd5:    rdata_d = cyc_hi_q;
          3'd6:    rdata_d = {16'b0, 8'(count), 6'b0, full, empty};
          default: rdata_d = '0;
        endcase
      end
    end

    if (term_wr && state_q != ST_DONE) begin
      case (off)
        3'd1: pass_pend_d = 1'b1;
        3'd2: fail_pend_d = 1'b1;
        default: begin
          exit_pend_d = 1'b1;
          exit_val_d  = data_wdata_i;
        end
      endcase
    end

    // Pulse lands in the first DRAIN cycle whose FIFO is empty; writes granted in the
    // deciding cycle still take part in the priority choice.
    case (state_q)
      ST_RUN:   if (term_wr) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d = ST_DONE;
          if (fail_pend_d) begin
            failed_d = 1'b1;
          end else if (exit_pend_d) begin
            exit_valid_d = 1'b1;
            exit_value_d = exit_val_d;
          end else begin
            passed_d = 1'b1;
          end
        end
      end
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cyc_q        <= '0;
      cyc_hi_q     <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      pass_pend_q  <= 1'b0;
      fail_pend_q  <= 1'b0;
      exit_pend_q  <= 1'b0;
      exit_val_q   <= '0;
      passed_q     <= 1'b0;
      failed_q     <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cyc_q        <= cyc_d;
      cyc_hi_q     <= cyc_hi_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      pass_pend_q  <= pass_pend_d;
      fail_pend_q  <= fail_pend_d;
      exit_pend_q  <= exit_pend_d;
      exit_val_q   <= exit_val_d;
      passed_q     <= passed_d;
      failed_q     <= failed_d;
      exit_valid_q <= exit_valid_d;
      exit_value_q <= exit_value_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_wdata_i[7:0];
  end

  assign char_valid_o   = !empty;
  assign char_data_o    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign data_rvalid_o  = rvalid_q;
  assign data_rdata_o   = rdata_q;
  assign data_err_o     = err_q;
  assign tests_passed_o = passed_q;
  assign tests_failed_o = failed_q;
  assign exit_valid_o   = exit_valid_q;
  assign exit_value_o   = exit_value_q;
endmodule

// File: tb/tb_tb_status_responder.sv
// Bench for tb_status_responder: directed scenarios plus random traffic, all checked every
// cycle against a queue-based reference model of the register window.
module tb_tb_status_responder;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 16;

  logic        clk, rst_ni;
  logic        req, gnt, we, rvalid, err, char_valid, char_ready;
  logic        passed, failed, exit_valid;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata, exit_value;
  logic [7:0]  char_data;

  tb_status_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
    .data_err_o(err), .char_valid_o(char_valid), .char_data_o(char_data),
    .char_ready_i(char_ready), .tests_passed_o(passed), .tests_failed_o(failed),
    .exit_valid_o(exit_valid), .exit_value_o(exit_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: FIFO as a queue, cycle index, termination bookkeeping.
  logic [7:0]      mq[$];
  logic [7:0]      obs[$];
  bit              exp_rv, exp_er;
  logic [31:0]     exp_rd, mhi, pval, last_exit;
  longint unsigned mcyc, g_cyc;
  int              phase;  // 0 running, 1 waiting for drain, 2 finished
  bit              pp, pf, pe;
  int              n_pass, n_fail, n_exit;

  bit              ok, eg, is_pr, ep, ef, ee;
  logic [31:0]     moff;

  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_char_valid", char_valid, 0);
      chk("rst_char_data", char_data, 0);
      chk("rst_pass", passed, 0);
      chk("rst_fail", failed, 0);
      chk("rst_exit", exit_valid, 0);
      chk("rst_exit_value", exit_value, 0);
      mq.delete();
      exp_rv = 0; exp_er = 0; exp_rd = 0; mhi = 0; pval = 0;
      mcyc = 0; g_cyc = 0; phase = 0; pp = 0; pf = 0; pe = 0;
    end else begin
      ep = 0; ef = 0; ee = 0;
      if (phase == 1 && mcyc >= g_cyc + 2 && mq.size() == 0) begin
        phase = 2;
        if (pf) ef = 1;
        else if (pe) ee = 1;
        else ep = 1;
      end
      chk("pass_pulse", passed, ep);
      chk("fail_pulse", failed, ef);
      chk("exit_pulse", exit_valid, ee);
      if (ee) chk("exit_value", exit_value, pval);
      chk("rvalid", rvalid, exp_rv);
      if (exp_rv) begin
        chk("rdata", rdata, exp_rd);
        chk("err", err, exp_er);
      end
      chk("char_valid", char_valid, mq.size() > 0);
      if (mq.size() > 0) chk("char_data", char_data, mq[0]);

      moff  = addr - BASE;
      ok    = (moff < 32'd28) && (addr[1:0] == 2'b00);
      is_pr = req && we && ok && moff == 0;
      eg    = req && !(is_pr && mq.size() == DEPTH);
      chk("gnt", gnt, eg);

      if (passed) n_pass++;
      if (failed) n_fail++;
      if (exit_valid) begin n_exit++; last_exit = exit_value; end
      if (char_valid && char_ready) obs.push_back(char_data);

      exp_rv = eg; exp_rd = 0; exp_er = 0;
      if (eg) begin
        if (!ok) exp_er = 1;
        else if (!we) begin
          if (moff == 16) begin exp_rd = mcyc[31:0]; mhi = mcyc[63:32]; end
          else if (moff == 20) exp_rd = mhi;
          else if (moff == 24)
            exp_rd = (mq.size() << 8) | ((mq.size() == DEPTH) ? 2 : 0) | ((mq.size() == 0) ? 1 : 0);
        end else if (phase != 2 && (moff == 4 || moff == 8 || moff == 12)) begin
          if (phase == 0) begin phase = 1; g_cyc = mcyc; end
          if (moff == 4) pp = 1;
          if (moff == 8) pf = 1;
          if (moff == 12) begin pe = 1; pval = wdata; end
        end
      end
      if (mq.size() > 0 && char_ready) void'(mq.pop_front());
      if (eg && is_pr && be[0]) mq.push_back(wdata[7:0]);
      mcyc++;
    end
  end

  task automatic bus(input logic [31:0] a, input bit w, input logic [3:0] b, input logic [31:0] d,
                     output logic [31:0] rd, output bit er, output int lat);
    lat = 0;
    @(posedge clk); #1;
    req = 1; addr = a; we = w; be = b; wdata = d;
    do begin @(negedge clk); lat++; end while (!gnt && lat < 200);
    if (!gnt) begin
      total++; bad++;
      $display("FAIL gnt_timeout: no grant for addr %0h after %0d cycles", a, lat);
    end
    @(posedge clk); #1;
    req = 0;
    @(negedge clk);
    rd = rdata; er = err;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req = 0; rst_ni = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
    n_pass = 0; n_fail = 0; n_exit = 0; obs.delete();
  endtask

  logic [31:0] rd, lo1, hi1, lo2, hi2;
  bit          er, g_last;
  int          lat, n, r;

  initial begin
    rst_ni = 0; req = 0; we = 0; be = 0; addr = 0; wdata = 0; char_ready = 0;
    n_pass = 0; n_fail = 0; n_exit = 0; last_exit = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;

    // Print path with an always-ready sink.
    char_ready = 1;
    for (int i = 0; i < 3; i++) begin
      bus(BASE, 1, 4'hF, 32'h41 + i, rd, er, lat);
      chk("print_gnt_lat", lat, 1);
    end
    repeat (3) @(posedge clk);
    chk("abc_count", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("char_A", obs[0], 8'h41); chk("char_B", obs[1], 8'h42); chk("char_C", obs[2], 8'h43);
    end
    bus(BASE + 32'h18, 0, 4'hF, 0, rd, er, lat);
    chk("status_empty", rd, 32'h1);

    // Fill to full, backpressure on the 17th write.
    char_ready = 0; obs.delete();
    for (int i = 0; i < 16; i++) bus(BASE, 1, 4'h1, 32'h60 + i, rd, er, lat);
    bus(BASE + 32'h18, 0, 4'hF, 0, rd, er, lat);
    chk("status_full", rd, 32'h1002);
    @(posedge clk); #1;
    req = 1; we = 1; addr = BASE; be = 4'h1; wdata = 32'h51;
    repeat (3) begin @(negedge clk); chk("full_backpressure", gnt, 0); end
    @(posedge clk); #1 char_ready = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt && n < 50);
    chk("full_release_lat", n, 2);
    @(posedge clk); #1 req = 0;
    repeat (25) @(posedge clk);
    chk("drain_count", obs.size(), 17);
    if (obs.size() == 17) begin
      chk("drain_first", obs[0], 8'h60); chk("drain_last", obs[16], 8'h51);
    end

    // Exit held back until buffered characters drain.
    char_ready = 0;
    for (int i = 0; i < 3; i++) bus(BASE, 1, 4'h1, 32'h30 + i, rd, er, lat);
    bus(BASE + 32'hC, 1, 4'h0, 32'h5, rd, er, lat);
    repeat (5) @(posedge clk);
    chk("exit_held", n_exit, 0);
    #1 char_ready = 1;
    repeat (10) @(posedge clk);
    chk("exit_once", n_exit, 1);
    chk("exit_code", last_exit, 32'h5);
    chk("exit_no_pass", n_pass + n_fail, 0);

    // PASS then FAIL back to back: FAIL wins, later EXIT ignored.
    do_reset();
    @(posedge clk); #1;
    req = 1; we = 1; be = 4'hF; wdata = 0; addr = BASE + 32'h4;
    @(posedge clk); #1 addr = BASE + 32'h8;
    @(posedge clk); #1 req = 0;
    repeat (5) @(posedge clk);
    chk("fail_once", n_fail, 1);
    chk("no_pass", n_pass, 0);
    bus(BASE + 32'hC, 1, 4'hF, 32'h7, rd, er, lat);
    chk("exit_write_err", er, 0);
    repeat (4) @(posedge clk);
    chk("done_no_exit", n_exit, 0);

    // Error responses and the cycle counter.
    bus(BASE + 32'h40, 0, 4'hF, 0, rd, er, lat);
    chk("oob_err", er, 1); chk("oob_rdata", rd, 0);
    bus(BASE + 32'h2, 0, 4'hF, 0, rd, er, lat);
    chk("misalign_err", er, 1); chk("misalign_rdata", rd, 0);
    bus(BASE + 32'h4, 0, 4'hF, 0, rd, er, lat);
    chk("wo_read_err", er, 0); chk("wo_read_rdata", rd, 0);
    bus(BASE + 32'h10, 0, 4'hF, 0, lo1, er, lat);
    bus(BASE + 32'h14, 0, 4'hF, 0, hi1, er, lat);
    bus(BASE + 32'h10, 0, 4'hF, 0, lo2, er, lat);
    bus(BASE + 32'h14, 0, 4'hF, 0, hi2, er, lat);
    chk("cyc_increasing", {hi2, lo2} > {hi1, lo1}, 1);
    chk("cyc_gap", {hi2, lo2} - {hi1, lo1}, 4);

    // Reset between grant and response with characters buffered.
    char_ready = 0;
    bus(BASE, 1, 4'h1, 32'h58, rd, er, lat);
    bus(BASE, 1, 4'h1, 32'h59, rd, er, lat);
    @(posedge clk); #1;
    req = 1; we = 0; addr = BASE + 32'h18;
    @(negedge clk);
    chk("mid_gnt", gnt, 1);
    chk("mid_char_valid", char_valid, 1);
    #2 rst_ni = 0; req = 0;
    #1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_char_valid", char_valid, 0);
    @(posedge clk); @(posedge clk); #1 rst_ni = 1;
    n_pass = 0; n_fail = 0; n_exit = 0; obs.delete();
    @(negedge clk);
    chk("post_rst_char_valid", char_valid, 0);
    chk("post_rst_rvalid", rvalid, 0);

    // Random traffic with periodic asynchronous resets.
    g_last = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      char_ready = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      if (c % 600 == 599) begin
        req = 0;
        @(negedge clk); #2 rst_ni = 0;
        @(posedge clk); @(posedge clk); #1 rst_ni = 1;
        g_last = 0;
        continue;
      end
      if (!req || g_last) begin
        req = ($urandom_range(0, 99) >= 30);
        we = 0; be = 4'(($urandom_range(0, 15))); wdata = $urandom;
        r = $urandom_range(0, 99);
        if (r < 45)      begin addr = BASE; we = 1; be[0] = 1'b1; end
        else if (r < 55) addr = BASE + 32'h18;
        else if (r < 62) addr = BASE + 32'h10;
        else if (r < 68) addr = BASE + 32'h14;
        else if (r < 72) addr = BASE + 32'(4 * $urandom_range(0, 3));
        else if (r < 76) begin addr = BASE + 32'h20 + 32'(4 * $urandom_range(0, 15)); we = 1'($urandom_range(0, 1)); end
        else if (r < 80) begin addr = BASE + 32'($urandom_range(1, 3)); we = 1'($urandom_range(0, 1)); end
        else if (r < 83) begin addr = BASE + 32'h10; we = 1; end
        else if (r < 86) begin addr = BASE; we = 1; be[0] = 1'b0; end
        else if (r < 87) begin addr = BASE + 32'h4; we = 1; end
        else if (r < 88) begin addr = BASE + 32'h8; we = 1; end
        else if (r < 89) begin addr = BASE + 32'hC; we = 1; end
        else             addr = BASE - 32'(4 * $urandom_range(1, 64));
      end
      @(negedge clk);
      g_last = gnt;
    end
    @(posedge clk); #1 req = 0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
